// File: rtl/upcounter_sched.sv
// Round-robin scheduler that lends one shared 8-bit UpCounter to NUM_REQ requesters.
// Each grant clears the counter, enables it for len cycles, and returns the final count.
module upcounter_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LEN_W-1:0] len_i,
  input  logic [WIDTH-1:0]         cnt_value_i,
  output logic                     cnt_clr_o,
  output logic                     cnt_en_o,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     abort_o,
  output logic [WIDTH-1:0]         result_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, owner, pick, cand;
  logic [IDX_W:0]   sum;
  logic             pick_valid;
  logic [LEN_W-1:0] rem;
  logic             aborted;
  logic             owner_req;
  logic [LEN_W-1:0] len_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_len
    assign len_arr[k] = len_i[k*LEN_W +: LEN_W];
  end

  assign owner_req = req_i[owner];

  // Walk downward so the closest set bit at or after ptr is the last one written.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (req_i[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr_o = 1'b0;
    cnt_en_o  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clr_o = 1'b1;
        if (!owner_req || rem == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // A dropped request silences the enable in the very cycle it falls.
        if (!owner_req) begin
          state_nxt = DONE;
        end else begin
          cnt_en_o = 1'b1;
          if (rem == LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_o = '0;
    if (state != IDLE) begin
      gnt_o[owner] = 1'b1;
    end
  end

  assign busy_o  = (state != IDLE);
  assign done_o  = (state == DONE);
  assign abort_o = (state == DONE) && aborted;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      rem      <= '0;
      aborted  <= 1'b0;
      result_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner   <= pick;
            rem     <= len_arr[pick];
            aborted <= 1'b0;
          end
        end
        CLEAR: begin
          if (!owner_req) begin
            aborted <= 1'b1;
          end
        end
        RUN: begin
          if (!owner_req) begin
            aborted <= 1'b1;
          end else begin
            rem <= rem - 1'b1;
          end
        end
        DONE: begin
          result_o <= cnt_value_i;
          ptr      <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upcounter_sched.sv
// Randomized and directed bench for upcounter_sched with a transaction-level model
// of round-robin grants, burst lengths, aborts and returned counter values.
module tb_upcounter_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int LEN_W   = 8;

  typedef enum int {M_IDLE, M_BURST, M_POST} model_state_t;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*LEN_W-1:0] len = '0;
  logic [WIDTH-1:0]         cnt_value;
  logic                     cnt_clr, cnt_en, busy, done, abort;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         result;

  int           errors = 0;
  int           checks = 0;
  model_state_t m_state = M_IDLE;
  int           ptr_m, owner_m, len_m, exp_en, exp_result, en_seen, clr_seen, burst_cycles;
  bit           exp_abort;
  bit           rand_mode = 1'b0;
  int           drop_d [NUM_REQ];
  int           rearm_left [NUM_REQ];
  bit           done_flag [NUM_REQ];
  logic [NUM_REQ-1:0]       edge_req;
  logic [NUM_REQ*LEN_W-1:0] edge_len;
  int           grant_log [$];
  int           t2_exp [5] = '{0, 1, 2, 3, 0};

  always #5 clock = ~clock;

  upcounter_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .req_i(req), .len_i(len), .cnt_value_i(cnt_value),
    .cnt_clr_o(cnt_clr), .cnt_en_o(cnt_en), .gnt_o(gnt), .busy_o(busy),
    .done_o(done), .abort_o(abort), .result_o(result)
  );

  // Stand-in for the shared external UpCounter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_value <= '0;
    else if (cnt_clr) cnt_value <= '0;
    else if (cnt_en) cnt_value <= cnt_value + 1'b1;
  end

  task automatic checkOutput(string tag, int observed, int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int rrPick(logic [NUM_REQ-1:0] r, int p);
    logic [NUM_REQ-1:0] s;
    for (int i = 0; i < NUM_REQ; i++) begin
      s = r >> ((p + i) % NUM_REQ);
      if (s[0]) return (p + i) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic bit reqBit(int k);
    logic [NUM_REQ-1:0] s;
    s = req >> k;
    return s[0];
  endfunction

  task automatic setReq(int k, bit v);
    if (v) req = req | (NUM_REQ'(1) << k);
    else   req = req & ~(NUM_REQ'(1) << k);
  endtask

  task automatic setLen(int k, int v);
    len[k*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  task automatic raise(int k, int l, int d, int rearm);
    setLen(k, l);
    drop_d[k]     = d;
    rearm_left[k] = rearm;
    setReq(k, 1'b1);
  endtask

  task automatic raiseRandom(int k);
    int l, d;
    l = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
    d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, l)) : -1;
    raise(k, l, d, ($urandom_range(0, 3) == 0) ? 1 : 0);
  endtask

  task automatic resetModel();
    m_state = M_IDLE;
    ptr_m = 0; exp_result = 0; en_seen = 0; clr_seen = 0; burst_cycles = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      drop_d[k] = -1; rearm_left[k] = 0; done_flag[k] = 1'b0;
    end
  endtask

  // Requester behaviour: release after done (or re-request), drop early for aborts, random arrivals.
  task automatic applyStimulus();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (done_flag[k]) begin
        done_flag[k] = 1'b0;
        if (rearm_left[k] > 0) begin
          rearm_left[k]--;
          drop_d[k] = -1;
          setReq(k, 1'b1);
        end else begin
          setReq(k, 1'b0);
        end
      end else if (m_state == M_BURST && owner_m == k && drop_d[k] >= 0 && en_seen >= drop_d[k]) begin
        setReq(k, 1'b0);
      end
      if (rand_mode && !(m_state == M_BURST && owner_m == k)) begin
        if (!reqBit(k) && $urandom_range(0, 3) == 0) raiseRandom(k);
        else if ($urandom_range(0, 15) == 0) setLen(k, int'($urandom_range(0, 9)));
      end else if (rand_mode && $urandom_range(0, 15) == 0) begin
        setLen(k, int'($urandom_range(0, 255)));
      end
    end
  endtask

  task automatic monitorCycle();
    int w;
    logic [LEN_W-1:0] lv;
    checkOutput("clr_en_excl", int'(cnt_clr & cnt_en), 0);
    case (m_state)
      M_IDLE: begin
        w = rrPick(edge_req, ptr_m);
        checkOutput("gnt_arb", int'(gnt), (w < 0) ? 0 : int'(NUM_REQ'(1) << w));
        checkOutput("busy_arb", int'(busy), (w < 0) ? 0 : 1);
        checkOutput("done_idle", int'(done), 0);
        checkOutput("result_hold", int'(result), exp_result);
        if (w >= 0) begin
          grant_log.push_back(w);
          owner_m = w;
          lv = LEN_W'(edge_len >> (w * LEN_W));
          len_m = int'(lv);
          exp_abort = (drop_d[w] >= 0 && drop_d[w] < len_m);
          exp_en = exp_abort ? drop_d[w] : len_m;
          en_seen = int'(cnt_en);
          clr_seen = int'(cnt_clr);
          burst_cycles = 1;
          m_state = M_BURST;
        end
      end
      M_BURST: begin
        checkOutput("gnt_burst", int'(gnt), int'(NUM_REQ'(1) << owner_m));
        checkOutput("busy_burst", int'(busy), 1);
        en_seen += int'(cnt_en);
        clr_seen += int'(cnt_clr);
        burst_cycles++;
        if (done) begin
          checkOutput("en_cycles", en_seen, exp_en);
          checkOutput("clr_cycles", clr_seen, 1);
          checkOutput("abort_flag", int'(abort), int'(exp_abort));
          exp_result = exp_en % (1 << WIDTH);
          ptr_m = (owner_m + 1) % NUM_REQ;
          done_flag[owner_m] = 1'b1;
          m_state = M_POST;
        end else begin
          checkOutput("abort_no_done", int'(abort), 0);
          if (burst_cycles > len_m + 3) begin
            checkOutput("burst_timeout", burst_cycles, len_m + 3);
            done_flag[owner_m] = 1'b1;
            m_state = M_IDLE;
          end
        end
      end
      default: begin
        checkOutput("gnt_post", int'(gnt), 0);
        checkOutput("busy_post", int'(busy), 0);
        checkOutput("done_post", int'(done), 0);
        checkOutput("result_post", int'(result), exp_result);
        m_state = M_IDLE;
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clock);
    edge_req = req;
    edge_len = len;
    #1;
    applyStimulus();
    @(negedge clock);
    monitorCycle();
  endtask

  task automatic waitQuiet(int budget, string tag);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(req == '0 && m_state == M_IDLE) && n < budget);
    if (!(req == '0 && m_state == M_IDLE))
      checkOutput({tag, "_timeout"}, int'(req != '0) + int'(m_state != M_IDLE), 0);
  endtask

  task automatic checkReset(string tag);
    checkOutput({tag, "_gnt"}, int'(gnt), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_abort"}, int'(abort), 0);
    checkOutput({tag, "_clr"}, int'(cnt_clr), 0);
    checkOutput({tag, "_en"}, int'(cnt_en), 0);
    checkOutput({tag, "_result"}, int'(result), 0);
  endtask

  initial begin
    int n;
    resetModel();
    #2 reset = 1'b0;
    #1 checkReset("por");
    @(posedge clock);
    #1 reset = 1'b1;

    // All four requesters at once; requester 0 asks again while still holding its line.
    grant_log.delete();
    raise(0, 1, -1, 1);
    for (int k = 1; k < NUM_REQ; k++) raise(k, 1, -1, 0);
    waitQuiet(200, "t2");
    checkOutput("t2_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) checkOutput("t2_order", grant_log[i], t2_exp[i]);

    raise(0, 5, -1, 0);
    waitQuiet(100, "t1");
    checkOutput("t1_result", int'(result), 5);

    raise(2, 0, -1, 0);
    waitQuiet(100, "t3");
    checkOutput("t3_result", int'(result), 0);

    raise(1, 10, 3, 0);
    waitQuiet(100, "t4");
    checkOutput("t4_result", int'(result), 3);

    raise(3, 255, -1, 0);
    waitQuiet(400, "t6a");
    checkOutput("t6_result_255", int'(result), 255);
    raise(3, 1, -1, 0);
    waitQuiet(100, "t6b");
    checkOutput("t6_result_1", int'(result), 1);

    // Reset in the middle of a long burst.
    raise(0, 200, -1, 0);
    n = 0;
    while (!(m_state == M_BURST && en_seen >= 50) && n < 300) begin
      cycle();
      n++;
    end
    checkOutput("t5_progress", int'(m_state == M_BURST && en_seen >= 50), 1);
    @(posedge clock);
    #1 reset = 1'b0;
    #1 checkReset("mid_reset");
    resetModel();
    req = '0;
    len = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    grant_log.delete();
    raise(3, 4, -1, 0);
    waitQuiet(100, "t5");
    checkOutput("t5_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 3);
    checkOutput("t5_result", int'(result), 4);

    rand_mode = 1'b1;
    repeat (3000) cycle();
    rand_mode = 1'b0;
    waitQuiet(3000, "random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
